aes_round_sequencer: RTL
========================

// Module: aes_round_sequencer
// PURPOSE
//   Iterative AES-128 encryption controller. Accepts one plaintext/key pair over a valid/ready handshake.
//   Runs the 10 AES rounds at one round per clock through a single combinational round datapath.
//   The datapath is SubBytes -> ShiftRows -> MixColumns -> AddRoundKey; MixColumns is bypassed in round 10.
//   Round keys are expanded on the fly. Ciphertext is returned over a second valid/ready handshake.
// PARAMETERS
//   BLOCK_W  128  state/key width in bits; only 128 is supported
//   NR       10   number of rounds; only 10 (AES-128) is supported
// PORTS
//   clk        in   1    single clock, rising edge
//   rst        in   1    reset, synchronous, active-high
//   in_valid   in   1    in_text/in_key are valid
//   in_ready   out  1    block can accept a new pair
//   in_text    in   128  plaintext, [0:127], byte 0 = bits [0:7], column-major state order
//   in_key     in   128  cipher key, same ordering as in_text
//   out_valid  out  1    out_text holds a finished ciphertext
//   out_ready  in   1    consumer accepts out_text
//   out_text   out  128  ciphertext, same ordering as in_text
//   busy       out  1    high while in ROUND state
//   round_idx  out  4    current round number, 0 in IDLE/DONE
// BEHAVIOUR
//   Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, round_idx=0.
//     out_text, state reg and key reg are cleared to 0.
//   FSM states: IDLE, ROUND, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready at edge T:
//     state_reg <= in_text ^ in_key (round-0 AddRoundKey); key_reg <= in_key;
//     rcon <= 8'h01; round <= 1; go to ROUND.
//   ROUND: in_ready=0, busy=1. Each edge:
//     k' = expand(key_reg, rcon) = one AES-128 key-schedule step.
//     state_reg <= AddRoundKey(MC(SR(SB(state_reg))), k'), with MC omitted when round==10.
//     key_reg <= k'; rcon <= xtime(rcon), giving 01,02,04,08,10,20,40,80,1B,36.
//     When round==10, go to DONE; otherwise round <= round+1.
//   DONE: out_valid=1, out_text=state_reg, held stable while out_ready=0.
//     On out_valid&out_ready, go to IDLE.
//   Latency: accept at edge T -> out_valid high from the edge at T+10 onward.
//     Minimum spacing is 12 cycles per block.
//   in_valid outside IDLE is ignored; inputs are not sampled and there are no side effects.
//   in_ready and out_valid are never high in the same cycle.
//   rst has priority over every event. Reset mid-ROUND or in DONE discards the block.
//     The next cycle shows IDLE reset values.
//   round_idx counts 1..10 in ROUND, with no wrap-around. rcon is reloaded only on acceptance.
// CONFIGURATION
//   AES_ABORT_EN defined:
//     Adds port abort (in, 1).
//     abort high in ROUND or DONE returns to IDLE at the next edge and drops the block.
//     out_valid is 0 the next cycle. abort is ignored in IDLE. rst has priority over abort.
//   AES_ABORT_EN undefined: no abort port; a block always runs to DONE.
// STRUCTURE
//   Shared include aes_defs.vh: AES_BLOCK_W, AES_NR, FSM state encodings (IDLE/ROUND/DONE),
//     RCON_INIT=8'h01, xtime function.
//   Sub-module aes_key_expand_step: combinational; (key[0:127], rcon[7:0]) -> next_key[0:127].
//     Implements RotWord, SubWord and Rcon XOR, plus the w[i]=w[i-1]^w[i-4] chain.
//   Round datapath instantiates the existing SubBytes, ShiftRows, MixColumns and AddRoundKey
//     blocks, plus a MixColumns bypass mux.
// TESTING
//   1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//      -> out_text 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 edges after accept.
//   2. FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//      -> 3925841d02dc09fbdc118597196a0b32; round_idx steps 1..10.
//   3. Backpressure: out_ready low for 5 cycles in DONE -> out_text stable, in_ready=0.
//      Then out_ready=1 -> IDLE on the next cycle and in_ready=1.
//   4. Back-to-back: in_valid held high with vector 2 during vector 1's rounds.
//      -> vector 1 is unaffected; vector 2 is accepted only after vector 1 is consumed.
//   5. Reset mid-run: assert rst at round_idx=5 -> next cycle in_ready=1, out_valid=0, busy=0.
//      Vector 1 rerun then gives the correct ciphertext.
//   6. AES_ABORT_EN: abort at round_idx=3 -> IDLE next cycle, no out_valid.
//      Vector 2 then passes; without the macro the same bench compiles with no abort port.

Source files
------------

// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES-128 definitions: widths, FSM encoding, round constant and GF(2^8) helpers.
// Pure combinational functions; no state.
// Blocks are 128-bit, byte 0 in bits [127:120], bytes in column-major state order.
package aes_round_sequencer_pkg;

  localparam int          AES_BLOCK_W = 128;
  localparam int          AES_NR      = 10;
  localparam logic [7:0]  RCON_INIT   = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, so 0 maps to 0) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Row r of the state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: RotWord, SubWord, Rcon XOR and the w[i]=w[i-1]^w[i-4] chain.
// Purely combinational, zero latency.
// No handshake; the caller registers the result.
module aes_key_expand_step
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] next_key_o
);

  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  assign w0   = key_i[127:96];
  assign w1   = key_i[95:64];
  assign w2   = key_i[63:32];
  assign w3   = key_i[31:0];
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                ^ {rcon_i, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Latency: accept at edge T, out_valid from edge T+10; 12 cycles minimum per block.
// Holds the ciphertext while out_ready is low; in_ready only in IDLE. Option: AES_ABORT_EN adds abort.
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int NR      = AES_NR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_text,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_text,
  output logic               busy,
`ifdef AES_ABORT_EN
  input  logic               abort,
`endif
  output logic [3:0]         round_idx
);

  state_e       state_q, state_d;
  logic [127:0] text_q, text_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;

  logic [127:0] key_nxt;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] round_out;
  logic         last_round;

  aes_key_expand_step u_key_step (
    .key_i      (key_q),
    .rcon_i     (rcon_q),
    .next_key_o (key_nxt)
  );

  // Round datapath: SubBytes -> ShiftRows -> MixColumns (skipped in the last round) -> AddRoundKey.
  assign last_round = (round_q == 4'(NR));
  assign sr_out     = shift_rows(sub_bytes(text_q));
  assign mc_out     = mix_columns(sr_out);
  assign round_out  = (last_round ? sr_out : mc_out) ^ key_nxt;

  // State registers; rst wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      text_q  <= '0;
      key_q   <= '0;
      rcon_q  <= RCON_INIT;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      text_q  <= text_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in ROUND, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    text_d  = text_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          text_d  = in_text ^ in_key;
          key_d   = in_key;
          rcon_d  = RCON_INIT;
          round_d = 4'd1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        text_d = round_out;
        key_d  = key_nxt;
        rcon_d = xtime(rcon_q);
        if (last_round) state_d = ST_DONE;
        else            round_d = round_q + 4'd1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AES_ABORT_EN
    // Abort drops the block in flight; it has no effect in IDLE.
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
`endif
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ROUND);
  assign round_idx = busy ? round_q : 4'd0;
  assign out_text  = text_q;

endmodule
